ins_fetch: RTL

- Fetches the CNN training instruction stream from DDR and presents it one instruction at a time to the accelerator top's ins_valid/ins_ready/ins port.
- Sits directly upstream of the top-level instruction input.
- Host/CPU supplies a start address and instruction count. The block issues credit-limited DDR read bursts, buffers returned beats in a FIFO, unpacks DDR_W-wide beats into INST_W instructions, and pulses done after the last one is accepted.

---
 rtl/ins_fetch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ins_fetch.sv
// Instruction fetcher: credit-limited DDR read bursts into a beat FIFO,
// unpacked LSB-first into INST_W instructions on a valid/ready port.
module ins_fetch #(
   parameter int INST_W     = 128,
   parameter int DDR_W      = 512,
   parameter int DDR_ADDR_W = 32,
   parameter int BURST_W    = 8,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DDR_ADDR_W-1:0] start_addr,
   input  logic [15:0]           ins_num,
   output logic                  busy,
   output logic                  done,
   output logic [DDR_ADDR_W-1:0] ddr_addr,
   output logic [BURST_W-1:0]    ddr_size,
   output logic                  ddr_addr_valid,
   input  logic                  ddr_addr_ready,
   input  logic [DDR_W-1:0]      ddr_data,
   input  logic                  ddr_valid,
   output logic                  ddr_ready,
   output logic [INST_W-1:0]     ins,
   output logic                  ins_valid,
   input  logic                  ins_ready
);

   localparam int K          = DDR_W / INST_W;
   localparam int SEL_W      = (K > 1) ? $clog2(K) : 1;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int CW         = ((BURST_W > CNT_W) ? BURST_W : CNT_W) + 2;
   localparam int BEAT_BYTES = DDR_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_e;

   state_e                state_q, state_d;
   logic [DDR_ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]           ins_num_q, ins_num_d;
   logic [15:0]           beats_total_q, beats_total_d;
   logic [15:0]           beats_req_q, beats_req_d;
   logic [15:0]           beats_rcvd_q, beats_rcvd_d;
   logic [15:0]           ins_sent_q, ins_sent_d;
   logic [CNT_W-1:0]      outst_q, outst_d;
   logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [K-1:0][INST_W-1:0] mem_q [FIFO_DEPTH];

   logic              active, credit_ok, fifo_full, fifo_empty;
   logic              req_hs, beat_hs, beat_wr, ins_hs, last_ins, pop;
   logic [15:0]       remain;
   logic [BURST_W-1:0] size;
   logic [16:0]       total_calc;

   always_comb begin
      active     = (state_q == REQ) || (state_q == DRAIN);
      remain     = beats_total_q - beats_req_q;
      size       = (remain > 16'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(remain);
      // fifo+outstanding only shrinks while a request waits, so valid never drops under stall
      credit_ok  = (CW'(fifo_cnt_q) + CW'(outst_q) + CW'(size)) <= CW'(FIFO_DEPTH);
      fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
      fifo_empty = (fifo_cnt_q == '0);

      ddr_addr       = addr_q;
      ddr_addr_valid = (state_q == REQ) && (remain != '0) && credit_ok;
      ddr_size       = (state_q == REQ) ? size : '0;
      ddr_ready      = active && !fifo_full;
      ins_valid      = active && !fifo_empty && (ins_sent_q < ins_num_q);
      ins            = ins_valid ? mem_q[rd_ptr_q][sel_q] : '0;
      busy           = active;
      done           = (state_q == FIN);

      req_hs   = ddr_addr_valid && ddr_addr_ready;
      beat_hs  = ddr_valid && ddr_ready;
      beat_wr  = beat_hs && (beats_rcvd_q != beats_total_q);
      ins_hs   = ins_valid && ins_ready;
      last_ins = ins_hs && (ins_sent_q == ins_num_q - 16'd1);
      pop      = ins_hs && ((sel_q == SEL_W'(K - 1)) || last_ins);

      total_calc = (17'(ins_num) + 17'(K - 1)) / 17'(K);

      state_d       = state_q;
      addr_d        = addr_q;
      ins_num_d     = ins_num_q;
      beats_total_d = beats_total_q;
      beats_req_d   = beats_req_q;
      beats_rcvd_d  = beats_rcvd_q;
      ins_sent_d    = ins_sent_q;
      outst_d       = outst_q;
      fifo_cnt_d    = fifo_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      sel_d         = sel_q;

      if (req_hs) begin
         addr_d      = addr_q + DDR_ADDR_W'(size) * DDR_ADDR_W'(BEAT_BYTES);
         beats_req_d = beats_req_q + 16'(size);
      end
      outst_d    = outst_q + (req_hs ? CNT_W'(size) : '0) - (beat_wr ? CNT_W'(1) : '0);
      fifo_cnt_d = fifo_cnt_q + (beat_wr ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
      if (beat_wr) begin
         beats_rcvd_d = beats_rcvd_q + 16'd1;
         wr_ptr_d     = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (ins_hs) begin
         ins_sent_d = ins_sent_q + 16'd1;
         sel_d      = pop ? '0 : sel_q + SEL_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d        = start_addr;
               ins_num_d     = ins_num;
               beats_total_d = total_calc[15:0];
               beats_req_d   = '0;
               beats_rcvd_d  = '0;
               ins_sent_d    = '0;
               outst_d       = '0;
               fifo_cnt_d    = '0;
               wr_ptr_d      = '0;
               rd_ptr_d      = '0;
               sel_d         = '0;
               state_d       = (ins_num == 16'd0) ? FIN : REQ;
            end
         end
         REQ:     if (req_hs && (beats_req_d == beats_total_q)) state_d = DRAIN;
         DRAIN:   if (last_ins) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         ins_num_q     <= '0;
         beats_total_q <= '0;
         beats_req_q   <= '0;
         beats_rcvd_q  <= '0;
         ins_sent_q    <= '0;
         outst_q       <= '0;
         fifo_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         sel_q         <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         ins_num_q     <= ins_num_d;
         beats_total_q <= beats_total_d;
         beats_req_q   <= beats_req_d;
         beats_rcvd_q  <= beats_rcvd_d;
         ins_sent_q    <= ins_sent_d;
         outst_q       <= outst_d;
         fifo_cnt_q    <= fifo_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         sel_q         <= sel_d;
      end
   end

   always_ff @(posedge clk) begin
      if (beat_wr) mem_q[wr_ptr_q] <= ddr_data;
   end

   a_no_extra_beat: assert property (@(posedge clk) disable iff (rst) !(beat_hs && !beat_wr));
   a_credit:        assert property (@(posedge clk) disable iff (rst) !(fifo_full && (outst_q != '0)));

endmodule
